// File: rtl/biquad8_seq_pkg.sv
// Shared constants and types for the biquad coefficient sequencer:
// register offsets within a biquad window, FSM states and coefficient sections.
package biquad8_seq_pkg;

   localparam logic [6:0] OFF_UPDATE = 7'h00;
   localparam logic [6:0] OFF_FIR    = 7'h04;
   localparam logic [6:0] OFF_IIR    = 7'h08;
   localparam logic [6:0] OFF_INC    = 7'h0C;
   localparam logic [6:0] OFF_POLE0  = 7'h10;
   localparam logic [6:0] OFF_POLE1  = 7'h14;
   localparam logic [6:0] OFF_POLE2  = 7'h18;
   localparam logic [6:0] OFF_POLE3  = 7'h1C;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_WRITE,
      ST_UPDATE,
      ST_DONE
   } state_e;

   // Sections in the order they are streamed to the filter.
   typedef enum logic [2:0] {
      SEC_FIR,
      SEC_POLE0,
      SEC_POLE1,
      SEC_POLE2,
      SEC_POLE3,
      SEC_IIR,
      SEC_INC
   } section_e;

   function automatic logic [6:0] sec_offset(section_e s);
      case (s)
         SEC_FIR:   return OFF_FIR;
         SEC_POLE0: return OFF_POLE0;
         SEC_POLE1: return OFF_POLE1;
         SEC_POLE2: return OFF_POLE2;
         SEC_POLE3: return OFF_POLE3;
         SEC_IIR:   return OFF_IIR;
         default:   return OFF_INC;
      endcase
   endfunction

   function automatic section_e next_section(section_e s);
      case (s)
         SEC_FIR:   return SEC_POLE0;
         SEC_POLE0: return SEC_POLE1;
         SEC_POLE1: return SEC_POLE2;
         SEC_POLE2: return SEC_POLE3;
         SEC_POLE3: return SEC_IIR;
         default:   return SEC_INC;
      endcase
   endfunction

endpackage

// File: rtl/biquad8_coeff_sequencer_if.sv
// WISHBONE master bus used by the coefficient sequencer to write biquad registers.
interface biquad8_coeff_sequencer_if;

   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [10:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_ack_i;
   logic        wb_err_i;

   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
      input  wb_ack_i, wb_err_i
   );

   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
      output wb_ack_i, wb_err_i
   );

endinterface

// File: rtl/biquad8_coeff_sequencer.sv
// Streams one biquad's coefficient set from a local RAM to its WISHBONE registers.
// Optional ack-wait timeout: define BIQUAD8_SEQ_TIMEOUT_EN.
module biquad8_coeff_sequencer
   import biquad8_seq_pkg::*;
#(
   parameter int N_FIR   = 4,
   parameter int N_POLE  = 8,
   parameter int N_IIR   = 7,
   parameter int N_INC   = 14,
   parameter int TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        start_i,
   input  logic [3:0]  target_i,
   input  logic        upd_en_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [5:0]  coeff_adr_o,
   input  logic [17:0] coeff_dat_i,
   biquad8_coeff_sequencer_if.master wb
);

   localparam int TOTAL = N_FIR + 4 * N_POLE + N_IIR + N_INC;

   state_e     state;
   section_e   sec;
   logic [5:0] sec_cnt;
   logic [3:0] target_q;
   logic       upd_q;
   logic       timeout_hit;
   logic       bus_fail;
   logic       last_coeff;

   function automatic logic [5:0] sec_last(section_e s);
      case (s)
         SEC_FIR:   return 6'(N_FIR - 1);
         SEC_IIR:   return 6'(N_IIR - 1);
         SEC_INC:   return 6'(N_INC - 1);
         default:   return 6'(N_POLE - 1);
      endcase
   endfunction

`ifdef BIQUAD8_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wait_cnt;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         wait_cnt <= '0;
      end else if (!wb.wb_stb_o || wb.wb_ack_i || wb.wb_err_i) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign timeout_hit = wb.wb_stb_o && (wait_cnt == TW'(TIMEOUT - 1));
`else
   localparam int unused_timeout = TIMEOUT;
   assign timeout_hit = 1'b0;
`endif

   assign bus_fail   = wb.wb_err_i | timeout_hit;
   assign last_coeff = (coeff_adr_o == 6'(TOTAL - 1));

   // NOTE: every register here is state, so all assignments are non-blocking;
   // blocking ones would let later statements see same-cycle updates.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state       <= ST_IDLE;
         sec         <= SEC_FIR;
         sec_cnt     <= '0;
         target_q    <= '0;
         upd_q       <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         coeff_adr_o <= '0;
         wb.wb_cyc_o <= 1'b0;
         wb.wb_stb_o <= 1'b0;
         wb.wb_we_o  <= 1'b0;
         wb.wb_adr_o <= '0;
         wb.wb_dat_o <= '0;
         wb.wb_sel_o <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  target_q    <= target_i;
                  upd_q       <= upd_en_i;
                  err_o       <= 1'b0;
                  busy_o      <= 1'b1;
                  coeff_adr_o <= '0;
                  sec         <= SEC_FIR;
                  sec_cnt     <= '0;
                  state       <= ST_FETCH;
               end
            end

            // RAM sees coeff_adr_o this cycle; its data is valid in LOAD.
            ST_FETCH: state <= ST_LOAD;

            ST_LOAD: begin
               wb.wb_adr_o <= {target_q, sec_offset(sec)};
               wb.wb_dat_o <= {14'b0, coeff_dat_i};
               wb.wb_sel_o <= 4'hF;
               wb.wb_we_o  <= 1'b1;
               wb.wb_cyc_o <= 1'b1;
               wb.wb_stb_o <= 1'b1;
               state       <= ST_WRITE;
            end

            ST_WRITE: begin
               if (bus_fail) begin
                  wb.wb_cyc_o <= 1'b0;
                  wb.wb_stb_o <= 1'b0;
                  wb.wb_we_o  <= 1'b0;
                  err_o       <= 1'b1;
                  busy_o      <= 1'b0;
                  done_o      <= 1'b1;
                  state       <= ST_DONE;
               end else if (wb.wb_ack_i) begin
                  wb.wb_cyc_o <= 1'b0;
                  wb.wb_stb_o <= 1'b0;
                  wb.wb_we_o  <= 1'b0;
                  if (!last_coeff) begin
                     coeff_adr_o <= coeff_adr_o + 6'd1;
                     if (sec_cnt == sec_last(sec)) begin
                        sec     <= next_section(sec);
                        sec_cnt <= '0;
                     end else begin
                        sec_cnt <= sec_cnt + 6'd1;
                     end
                     state <= ST_FETCH;
                  end else if (upd_q) begin
                     wb.wb_adr_o <= {target_q, OFF_UPDATE};
                     wb.wb_dat_o <= 32'h1;
                     state       <= ST_UPDATE;
                  end else begin
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                     state  <= ST_DONE;
                  end
               end
            end

            // First cycle strobe is low (previous write just closed), then strobe until ack.
            ST_UPDATE: begin
               if (!wb.wb_stb_o) begin
                  wb.wb_cyc_o <= 1'b1;
                  wb.wb_stb_o <= 1'b1;
                  wb.wb_we_o  <= 1'b1;
               end else if (bus_fail || wb.wb_ack_i) begin
                  wb.wb_cyc_o <= 1'b0;
                  wb.wb_stb_o <= 1'b0;
                  wb.wb_we_o  <= 1'b0;
                  err_o       <= bus_fail;
                  busy_o      <= 1'b0;
                  done_o      <= 1'b1;
                  state       <= ST_DONE;
               end
            end

            ST_DONE: begin
               done_o <= 1'b0;
               state  <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_biquad8_coeff_sequencer.sv
// Self-checking bench: a transaction-level model of the expected write stream
// is compared against every WISHBONE write the sequencer issues.
module tb_biquad8_coeff_sequencer;

   localparam int N_FIR   = 4;
   localparam int N_POLE  = 8;
   localparam int N_IIR   = 7;
   localparam int N_INC   = 14;
   localparam int TIMEOUT = 4;

   typedef struct packed {
      logic [10:0] adr;
      logic [31:0] dat;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  target = '0;
   logic        upd = 1'b0;
   logic        busy, done, err;
   logic [5:0]  coeff_adr;
   logic [17:0] coeff_dat = '0;

   biquad8_coeff_sequencer_if wb ();

   biquad8_coeff_sequencer #(
      .N_FIR(N_FIR), .N_POLE(N_POLE), .N_IIR(N_IIR), .N_INC(N_INC), .TIMEOUT(TIMEOUT)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_ni   (rst_n),
      .start_i     (start),
      .target_i    (target),
      .upd_en_i    (upd),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err),
      .coeff_adr_o (coeff_adr),
      .coeff_dat_i (coeff_dat),
      .wb          (wb)
   );

   always #5 clk = ~clk;

   // Registered coefficient RAM holding RAM[i] = i.
   always @(posedge clk) coeff_dat <= 18'(coeff_adr);

   int   n_vec = 0;
   int   n_err = 0;
   wr_t  exp_q[$];
   wr_t  obs_q[$];
   int   wr_cnt = 0;
   int   err_at = 0;
   int   stall_at = 0;
   bit   no_ack = 1'b0;
   bit   in_txn = 1'b0;
   wr_t  cap;
   wr_t  mon_w;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   // Expected write stream straight from the section table.
   task automatic model_load(input logic [3:0] tgt, input logic u);
      int offs[7];
      int lens[7];
      int idx;
      wr_t w;
      offs = '{'h04, 'h10, 'h14, 'h18, 'h1C, 'h08, 'h0C};
      lens = '{N_FIR, N_POLE, N_POLE, N_POLE, N_POLE, N_IIR, N_INC};
      idx = 0;
      exp_q.delete();
      for (int s = 0; s < 7; s++) begin
         for (int k = 0; k < lens[s]; k++) begin
            w.adr = {tgt, 7'(offs[s])};
            w.dat = 32'(idx);
            exp_q.push_back(w);
            idx++;
         end
      end
      if (u) begin
         w.adr = {tgt, 7'h00};
         w.dat = 32'h1;
         exp_q.push_back(w);
      end
   endtask

   // Slave + compare process: acks each strobe after one cycle and checks it against the model.
   initial begin
      wb.wb_ack_i = 1'b0;
      wb.wb_err_i = 1'b0;
   end

   always @(negedge clk) begin
      wb.wb_ack_i = 1'b0;
      wb.wb_err_i = 1'b0;
      if (wb.wb_cyc_o && wb.wb_stb_o) begin
         if (!in_txn) begin
            in_txn = 1'b1;
            wr_cnt++;
            cap.adr = wb.wb_adr_o;
            cap.dat = wb.wb_dat_o;
            obs_q.push_back(cap);
            check($sformatf("wr%0d_expected", wr_cnt), 32'(exp_q.size() != 0), 32'h1);
            if (exp_q.size() != 0) begin
               mon_w = exp_q.pop_front();
               check($sformatf("wr%0d_adr", wr_cnt), 32'(wb.wb_adr_o), 32'(mon_w.adr));
               check($sformatf("wr%0d_dat", wr_cnt), wb.wb_dat_o, mon_w.dat);
            end
            check($sformatf("wr%0d_sel", wr_cnt), 32'(wb.wb_sel_o), 32'hF);
            check($sformatf("wr%0d_we", wr_cnt), 32'(wb.wb_we_o), 32'h1);
         end else begin
            check("hold_adr", 32'(wb.wb_adr_o), 32'(cap.adr));
            check("hold_dat", wb.wb_dat_o, cap.dat);
         end
         if (wr_cnt == err_at) wb.wb_err_i = 1'b1;
         else if (!no_ack && wr_cnt != stall_at) wb.wb_ack_i = 1'b1;
      end else begin
         in_txn = 1'b0;
      end
      if (done) check("done_busy_low", 32'(busy), 32'h0);
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_cyc"}, 32'(wb.wb_cyc_o), 32'h0);
      check({tag, "_stb"}, 32'(wb.wb_stb_o), 32'h0);
      check({tag, "_we"}, 32'(wb.wb_we_o), 32'h0);
      check({tag, "_adr"}, 32'(wb.wb_adr_o), 32'h0);
      check({tag, "_dat"}, wb.wb_dat_o, 32'h0);
      check({tag, "_sel"}, 32'(wb.wb_sel_o), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_done"}, 32'(done), 32'h0);
      check({tag, "_err"}, 32'(err), 32'h0);
      check({tag, "_coeff_adr"}, 32'(coeff_adr), 32'h0);
   endtask

   // Inputs change after acceptance to prove target/upd are latched.
   task automatic start_load(input logic [3:0] tgt, input logic u);
      @(negedge clk);
      model_load(tgt, u);
      obs_q.delete();
      wr_cnt = 0;
      start  = 1'b1;
      target = tgt;
      upd    = u;
      @(negedge clk);
      start  = 1'b0;
      target = ~tgt;
      upd    = ~u;
      check("busy_after_start", 32'(busy), 32'h1);
      check("err_cleared_by_start", 32'(err), 32'h0);
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("done_seen", 32'(seen), 32'h1);
   endtask

   task automatic check_done_width();
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'h0);
      check("idle_busy_low", 32'(busy), 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int zero_off;
      int hi;
      bit reached;

      // Reset state
      repeat (3) @(negedge clk);
      check_all_zero("in_reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("after_reset");

      // Pin the model against hand-computed values
      model_load(4'd5, 1'b1);
      check("model_len", 32'(exp_q.size()), 32'd58);
      check("model_first_adr", 32'(exp_q[0].adr), 32'h284);
      check("model_w5_adr", 32'(exp_q[4].adr), 32'h290);
      check("model_w5_dat", exp_q[4].dat, 32'h4);
      check("model_last_adr", 32'(exp_q[57].adr), 32'h280);
      check("model_last_dat", exp_q[57].dat, 32'h1);

      // Full load with update; a start to target 9 mid-load must be ignored
      start_load(4'd5, 1'b1);
      repeat (30) @(negedge clk);
      start  = 1'b1;
      target = 4'd9;
      @(negedge clk);
      start  = 1'b0;
      wait_done(1000);
      check("t5_writes", 32'(wr_cnt), 32'd58);
      check("t5_model_drained", 32'(exp_q.size()), 32'd0);
      check("t5_err", 32'(err), 32'h0);
      if (obs_q.size() == 58) begin
         check("t5_first_adr", 32'(obs_q[0].adr), 32'h284);
         check("t5_first_dat", obs_q[0].dat, 32'h0);
         check("t5_w5_adr", 32'(obs_q[4].adr), 32'h290);
         check("t5_w5_dat", obs_q[4].dat, 32'h4);
         check("t5_last_adr", 32'(obs_q[57].adr), 32'h280);
         check("t5_last_dat", obs_q[57].dat, 32'h1);
      end
      check_done_width();
      repeat (5) @(negedge clk);
      check("t5_no_restart", 32'(busy), 32'h0);

      // No update write
      start_load(4'd3, 1'b0);
      wait_done(1000);
      check("t3_writes", 32'(wr_cnt), 32'd57);
      zero_off = 0;
      foreach (obs_q[i]) if (obs_q[i].adr[6:0] == 7'h00) zero_off++;
      check("t3_no_update", 32'(zero_off), 32'd0);
      check("t3_model_drained", 32'(exp_q.size()), 32'd0);
      check_done_width();

      // Bus error on write 10
      err_at = 10;
      start_load(4'd12, 1'b1);
      wait_done(1000);
      check("err_flag", 32'(err), 32'h1);
      check("err_cyc_low", 32'(wb.wb_cyc_o), 32'h0);
      check("err_stb_low", 32'(wb.wb_stb_o), 32'h0);
      check("err_writes", 32'(wr_cnt), 32'd10);
      check_done_width();
      repeat (20) @(negedge clk);
      check("err_no_more_writes", 32'(wr_cnt), 32'd10);
      check("err_sticky", 32'(err), 32'h1);
      err_at = 0;
      exp_q.delete();
      start_load(4'd2, 1'b1);
      wait_done(1000);
      check("after_err_writes", 32'(wr_cnt), 32'd58);
      check("after_err_err", 32'(err), 32'h0);
      check_done_width();

      // Reset in the middle of write 20
      stall_at = 20;
      start_load(4'd1, 1'b1);
      reached = 1'b0;
      for (int i = 0; i < 500 && !reached; i++) begin
         @(negedge clk);
         if (wr_cnt == 20 && wb.wb_stb_o) reached = 1'b1;
      end
      check("reached_write20", 32'(reached), 32'h1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("mid_reset");
      stall_at = 0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      start_load(4'd6, 1'b1);
      wait_done(1000);
      check("post_reset_writes", 32'(wr_cnt), 32'd58);
      if (obs_q.size() != 0) begin
         check("post_reset_first_adr", 32'(obs_q[0].adr), 32'h304);
         check("post_reset_first_dat", obs_q[0].dat, 32'h0);
      end
      check_done_width();

      // Slave that never acknowledges
      no_ack = 1'b1;
      start_load(4'd7, 1'b1);
`ifdef BIQUAD8_SEQ_TIMEOUT_EN
      hi = 0;
      reached = 1'b0;
      for (int i = 0; i < 100 && !reached; i++) begin
         @(negedge clk);
         if (wb.wb_stb_o) hi++;
         if (done) reached = 1'b1;
      end
      check("timeout_done", 32'(reached), 32'h1);
      check("timeout_stb_cycles", 32'(hi), 32'(TIMEOUT));
      check("timeout_err", 32'(err), 32'h1);
      check("timeout_writes", 32'(wr_cnt), 32'd1);
      check_done_width();
`else
      reached = 1'b0;
      for (int i = 0; i < 10 && !reached; i++) begin
         @(negedge clk);
         if (wb.wb_stb_o) reached = 1'b1;
      end
      check("noack_stb_seen", 32'(reached), 32'h1);
      hi = 0;
      repeat (1000) begin
         @(negedge clk);
         if (wb.wb_stb_o) hi++;
      end
      check("noack_stb_held", 32'(hi), 32'd1000);
      check("noack_busy", 32'(busy), 32'h1);
      check("noack_err", 32'(err), 32'h0);
      #2 rst_n = 1'b0;
      #1 check_all_zero("noack_reset");
      @(negedge clk);
      rst_n = 1'b1;
`endif
      no_ack = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/biquad8_coeff_sequencer.md
BIQUAD8_COEFF_SEQUENCER -- requirements
Module: biquad8_coeff_sequencer

Interface
REQ-001 SHALL have parameter N_FIR, default 4, FIR coefficient writes per load.
REQ-002 SHALL have parameter N_POLE, default 8, writes per pole-FIR sub-address (four sub-addresses).
REQ-003 SHALL have parameter N_IIR, default 7, IIR coefficient writes per load.
REQ-004 SHALL have parameter N_INC, default 14, incremental coefficient writes per load.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum ack-wait cycles.
REQ-006 SHALL have ports wb_clk_i (in, 1, sole clock) and wb_rst_ni (in, 1, asynchronous active-low reset).
REQ-007 SHALL have ports start_i (in, 1, load request), target_i (in, 4, biquad index 0-15) and upd_en_i (in, 1, issue the final update write).
REQ-008 SHALL have ports busy_o (out, 1), done_o (out, 1, one-cycle pulse) and err_o (out, 1, sticky, cleared by next accepted start).
REQ-009 SHALL have ports coeff_adr_o (out, 6, coefficient RAM index) and coeff_dat_i (in, 18, RAM data, valid one cycle after coeff_adr_o).
REQ-010 SHALL have WISHBONE master ports wb_cyc_o, wb_stb_o, wb_we_o (out, 1 each), wb_adr_o (out, 11), wb_dat_o (out, 32), wb_sel_o (out, 4), wb_ack_i and wb_err_i (in, 1 each).

Function
REQ-011 SHALL accept start_i only in IDLE; start_i while busy is ignored.
REQ-012 SHALL latch target_i and upd_en_i on acceptance and raise busy_o the next cycle.
REQ-013 SHALL write sections in order: FIR (offset 0x04, N_FIR), pole-FIR 0x10/0x14/0x18/0x1C (N_POLE each), IIR 0x08 (N_IIR), INC 0x0C (N_INC), then UPDATE 0x00 if upd_en_i was latched.
REQ-014 SHALL drive wb_adr_o = {target, 7-bit offset}.
REQ-015 SHALL drive wb_dat_o = {14'b0, coeff_dat_i} for coefficient writes and 32'h1 for UPDATE, with wb_sel_o = 4'hF and wb_we_o = 1.
REQ-016 SHALL set coeff_adr_o to a linear index from 0 to TOTAL-1 across sections, where TOTAL = N_FIR + 4*N_POLE + N_IIR + N_INC (default 57; shall not exceed 64).
REQ-017 SHALL implement FSM states IDLE -> FETCH (present address) -> LOAD (capture data) -> WRITE (cyc/stb held until ack/err) -> FETCH, or UPDATE after the last coefficient, or DONE.
REQ-018 SHALL hold adr/dat/sel stable while stb is high and deassert cyc/stb the cycle after ack; one write is outstanding at a time.
REQ-019 SHALL take 3 cycles minimum per write, so a default load with update takes at least 58×3 cycles.
REQ-020 SHALL, on wb_err_i, set err_o, drop cyc/stb, skip remaining writes including UPDATE, and go to DONE.
REQ-021 SHALL pulse done_o for one cycle in DONE and drop busy_o in the same cycle, returning to IDLE; a start in that cycle is ignored.
REQ-022 SHALL treat wb_ack_i or wb_err_i seen outside WRITE/UPDATE as ignored.

Reset
REQ-023 SHALL, on asserting wb_rst_ni=0 at any time including mid-cycle, force IDLE and drive cyc, stb, we, busy, done and err to 0, adr, dat, sel and coeff_adr_o to 0, and clear counters.

Configuration
REQ-024 SHALL, when BIQUAD8_SEQ_TIMEOUT_EN is defined, count ack-wait cycles and, after TIMEOUT cycles without ack/err, treat the write as wb_err_i (REQ-020).
REQ-025 SHALL, when BIQUAD8_SEQ_TIMEOUT_EN is undefined, wait indefinitely with no timeout counter logic.

Structure
REQ-026 SHALL put section offsets (0x00, 0x04, 0x08, 0x0C, 0x10-0x1C), a state enum and a section enum in package biquad8_seq_pkg.
REQ-027 SHALL be a single module with no sub-module; the WB interface uses the codebase master-port macro.

Verification
REQ-028 Scenario: target 5, upd_en 1, RAM[i]=i, ack after 1 cycle -> 58 writes; first adr 0x284 with dat 0x0; write 5 at adr 0x290 with dat 0x4; last write adr 0x280 with dat 0x1; done pulse.
REQ-029 Scenario: upd_en 0 -> exactly 57 writes, no write to offset 0x00.
REQ-030 Scenario: wb_err_i on write 10 -> err_o=1, cyc low next cycle, no further writes, done pulse; next start clears err_o.
REQ-031 Scenario: timeout enabled, TIMEOUT=4, ack never arrives -> stb drops after 4 wait cycles, err_o=1; timeout disabled -> stb stays high for 1000 cycles.
REQ-032 Scenario: reset asserted during write 20 -> all outputs 0 immediately; a new start then begins at coeff_adr 0.
REQ-033 Scenario: start pulsed while busy, with target 9 -> ignored; all writes keep the original target.
